// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package if_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} skid register that captures the presented instruction
// when decode stalls, so the memory can keep streaming behind it.
module fetch_skid_buf #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            load,
  input  logic            clear,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic            full
);

  logic            full_q, full_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  // Clear wins over load: a redirect must drop whatever is being captured.
  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d  = 1'b1;
      instr_d = in_instr;
      pc_d    = in_pc;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  always_ff @(posedge clock) begin
    instr_q <= instr_d;
    pc_q    <= pc_d;
  end

  assign instr = instr_q;
  assign pc    = pc_q;
  assign full  = full_q;

endmodule

// File: rtl/if_fetch_sequencer.sv
// IF-stage sequencer: owns the PC, drives a synchronous-read imem, and delivers a
// valid/ready stream with a 1-entry skid. Optional IF_PERF_CNT_EN adds perf counters.
module if_fetch_sequencer
  import if_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              IMEM_BYTES = 128
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt,
`endif
  input  logic            id_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam logic [XLEN-1:0] ADDR_MASK = XLEN'(IMEM_BYTES - 1);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            rsp_v_q, rsp_v_d;

  logic            skid_load, skid_clear, skid_full;
  logic [31:0]     skid_instr;
  logic [XLEN-1:0] skid_pc;

  logic            unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (skid_load),
    .clear    (skid_clear),
    .in_instr (if_instr),
    .in_pc    (if_pc),
    .instr    (skid_instr),
    .pc       (skid_pc),
    .full     (skid_full)
  );

  assign imem_addr = pc_q & ADDR_MASK;

  // Outputs depend only on registered state (imem_rdata is itself a register).
  always_comb begin
    if_valid = 1'b0;
    if_instr = NOP_INSTR;
    if_pc    = req_pc_q;
    case (state_q)
      RUN: begin
        if_valid = rsp_v_q;
        if_instr = rsp_v_q ? imem_rdata : NOP_INSTR;
      end
      HOLD: begin
        if_valid = skid_full;
        if_instr = skid_instr;
        if_pc    = skid_pc;
      end
      default: ;
    endcase
  end

  // Redirect has top priority; in HOLD the imem address is frozen on pc_q, so
  // imem_rdata already holds instr(pc_q) when the skid drains.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    rsp_v_d    = rsp_v_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
      rsp_v_d    = 1'b0;
      skid_clear = 1'b1;
      state_d    = RUN;
    end else begin
      case (state_q)
        IDLE: begin
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_STEP;
          rsp_v_d  = 1'b1;
          state_d  = RUN;
        end
        RUN: begin
          if (if_valid && !id_ready) begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end else begin
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_STEP;
            rsp_v_d  = 1'b1;
          end
        end
        HOLD: begin
          if (id_ready) begin
            skid_clear = 1'b1;
            req_pc_d   = pc_q;
            pc_d       = pc_q + PC_STEP;
            rsp_v_d    = 1'b1;
            state_d    = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      rsp_v_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      rsp_v_q  <= rsp_v_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

  always_comb begin
    perf_fetch_cnt_d = sat_inc(perf_fetch_cnt_q, if_valid & id_ready);
    perf_stall_cnt_d = sat_inc(perf_stall_cnt_q, if_valid & ~id_ready);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_cnt_q <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      perf_fetch_cnt_q <= perf_fetch_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_sequencer.sv
// Scoreboard bench for if_fetch_sequencer; perf-counter checks only when IF_PERF_CNT_EN is defined.
module tb_if_fetch_sequencer;

  logic        clock;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  if_fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0), .IMEM_BYTES(128)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read instruction memory, 32 words.
  logic [31:0] mem [32];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'h00500093;  // addi x1,x0,5
    mem[1] = 32'h0000A103;  // lw   x2,0(x1)
    mem[2] = 32'h002081B3;  // add  x3,x1,x2
    mem[3] = 32'h40208233;  // sub  x4,x1,x2
    mem[7] = 32'h003476B3;
  end
  always @(posedge clock) imem_rdata <= mem[imem_addr[6:2]];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb_q[$];
  exp_t sb_e;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem[pc[6:2]];
    sb_q.push_back(e);
  endtask

  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clock);
    #1;
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clock);
  endtask

  // Monitor: every accepted instruction (redirect cycles are ignored by the consumer).
  always @(negedge clock) begin
    if (reset_n && if_valid && id_ready && !redirect_valid) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h with empty queue", if_pc);
      end else begin
        sb_e = sb_q.pop_front();
        chk("sb_pc", if_pc, sb_e.pc);
        chk("sb_instr", if_instr, sb_e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_chk %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", if_valid, 0);
    chk("rst_instr", if_instr, 32'h00000013);
    chk("rst_pc", if_pc, 0);
    chk("rst_addr", imem_addr, 0);

    // Stream from reset, then redirect to 28 while pc 16 is shown.
    push(0); push(4); push(8); push(12); push(28); push(32);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_valid", if_valid, 0);
    repeat (4) cyc(1, 0, 0);
    cyc(1, 1, 32'd28);
    chk("redir_shown_pc", if_pc, 32'd16);
    cyc(1, 0, 0);
    chk("redir_bubble", if_valid, 0);
    cyc(1, 0, 0);
    chk("redir_tgt_instr", if_instr, 32'h003476B3);
    cyc(1, 0, 0);

    // Stall 3 cycles on pc 4.
    push(0); push(4); push(8); push(12);
    cyc(1, 1, 32'd0);
    cyc(1, 0, 0);
    chk("redir2_bubble", if_valid, 0);
    cyc(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(i == 3, 0, 0);
      chk("stall_valid", if_valid, 1);
      chk("stall_pc", if_pc, 32'd4);
      chk("stall_addr", imem_addr, 32'd8);
    end
    cyc(1, 0, 0);
    cyc(1, 0, 0);

    // Redirect during HOLD drops the skid; target LSBs ignored.
    push(32'h1C); push(32'h20);
    cyc(0, 0, 0);
    chk("hold_pc", if_pc, 32'd16);
    cyc(0, 1, 32'h1E);
    chk("hold_redir_pc", if_pc, 32'd16);
    cyc(1, 0, 0);
    chk("hold_redir_bubble", if_valid, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);

    // Wrap of imem_addr across the 128-byte boundary.
    push(116); push(120); push(124); push(128); push(132);
    cyc(1, 1, 32'd116);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("wrap_addr_124", imem_addr, 32'd124);
    cyc(1, 0, 0);
    chk("wrap_addr_0", imem_addr, 32'd0);
    chk("wrap_pc_124", if_pc, 32'd124);
    cyc(1, 0, 0);
    chk("wrap_pc_128", if_pc, 32'd128);
    cyc(1, 0, 0);

    // Asynchronous reset mid-stream.
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", if_valid, 0);
    chk("mid_rst_instr", if_instr, 32'h00000013);
    chk("mid_rst_pc", if_pc, 0);
    chk("mid_rst_addr", imem_addr, 0);
`ifdef IF_PERF_CNT_EN
    chk("mid_rst_fetch_cnt", perf_fetch_cnt, 0);
    chk("mid_rst_stall_cnt", perf_stall_cnt, 0);
`endif
    chk("mid_rst_sb_empty", sb_q.size(), 0);
    repeat (2) @(posedge clock);

    // 5 transfers and 3 stall cycles after a fresh reset.
    push(0); push(4); push(8); push(12); push(16);
    @(posedge clock);
    #1;
    reset_n  = 1'b1;
    id_ready = 1'b1;
    @(negedge clock);
    chk("idle2_valid", if_valid, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    repeat (3) cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("perf_run_pc", if_pc, 32'd20);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch_5", perf_fetch_cnt, 32'd5);
    chk("perf_stall_3", perf_stall_cnt, 32'd3);
    @(posedge clock);
    #1;
    force dut.perf_stall_cnt_q = 32'hFFFF_FFFE;
    @(negedge clock);
    release dut.perf_stall_cnt_q;
    cyc(0, 0, 0);
    chk("perf_stall_max", perf_stall_cnt, 32'hFFFF_FFFF);
    cyc(0, 0, 0);
    chk("perf_stall_sat", perf_stall_cnt, 32'hFFFF_FFFF);
    chk("perf_fetch_hold", perf_fetch_cnt, 32'd5);
`else
    repeat (3) cyc(0, 0, 0);
`endif
    chk("hold_end_pc", if_pc, 32'd20);
    chk("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
